// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with the N/Z/V condition-flag register and sticky halt tracking.
// Flags update only for captured instructions; flags_fwd exposes the next-edge flag value to decode.
module ex_mem_stage #(
    parameter int         WIDTH    = 16,
    parameter logic [2:0] FLAG_RST = 3'b000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [3:0]       ex_opcode,
    input  logic [WIDTH-1:0] ex_alu_out,
    input  logic             ex_ovfl,
    input  logic [WIDTH-1:0] ex_store_data,
    input  logic [3:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    output logic             mem_valid,
    output logic [3:0]       mem_opcode,
    output logic [WIDTH-1:0] mem_alu_out,
    output logic [WIDTH-1:0] mem_store_data,
    output logic [3:0]       mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [2:0]       flags,
    output logic [2:0]       flags_fwd,
    output logic             halted
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic             cap_s;
    logic             zero_s;
    logic [2:0]       flags_d;
    logic             valid_q;
    logic [3:0]       opcode_q;
    logic [WIDTH-1:0] alu_q;
    logic [WIDTH-1:0] store_q;
    logic [3:0]       rd_q;
    logic             reg_write_q;
    logic             mem_read_q;
    logic             mem_write_q;
    logic [2:0]       flags_q;
    logic             halted_q;

    // Capture qualifier and next flag value; flags are {N,Z,V}.
    always_comb begin
        cap_s   = ex_valid & ~stall & ~flush & ~halted_q;
        zero_s  = (ex_alu_out == {WIDTH{1'b0}});
        flags_d = flags_q;
        if (cap_s) begin
            case (ex_opcode)
                OP_ADD, OP_SUB:                 flags_d = {ex_alu_out[WIDTH-1], zero_s, ex_ovfl};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d = {flags_q[2], zero_s, flags_q[0]};
                default:                        flags_d = flags_q;
            endcase
        end else begin
            flags_d = flags_q;
        end
    end

    // Pipeline and flag state: rst > stall > flush > capture/bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            opcode_q    <= 4'b0000;
            alu_q       <= {WIDTH{1'b0}};
            store_q     <= {WIDTH{1'b0}};
            rd_q        <= 4'b0000;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            flags_q     <= FLAG_RST;
            halted_q    <= 1'b0;
        end else if (stall) begin
            valid_q <= valid_q;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= cap_s;
            opcode_q    <= ex_opcode;
            alu_q       <= ex_alu_out;
            store_q     <= ex_store_data;
            rd_q        <= ex_rd;
            reg_write_q <= ex_reg_write & cap_s;
            mem_read_q  <= ex_mem_read & cap_s;
            mem_write_q <= ex_mem_write & cap_s;
            flags_q     <= flags_d;
            halted_q    <= halted_q | (cap_s & (ex_opcode == OP_HLT));
        end
    end

    assign mem_valid      = valid_q;
    assign mem_opcode     = opcode_q;
    assign mem_alu_out    = alu_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign flags          = flags_q;
    assign flags_fwd      = flags_d;
    assign halted         = halted_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a per-cycle behavioural model checked on every falling edge,
// plus hand-computed expectations along the directed sequence.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        ex_valid, ex_ovfl, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_opcode, ex_rd;
    logic [15:0] ex_alu_out, ex_store_data;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, halted;
    logic [3:0]  mem_opcode, mem_rd;
    logic [15:0] mem_alu_out, mem_store_data;
    logic [2:0]  flags, flags_fwd;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // model state
    logic        m_valid, m_rw, m_mr, m_mw, m_halted;
    logic [3:0]  m_op, m_rd;
    logic [15:0] m_alu, m_sd;
    logic [2:0]  m_flags;

    ex_mem_stage #(.WIDTH(16), .FLAG_RST(3'b000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_alu_out(ex_alu_out),
        .ex_ovfl(ex_ovfl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_alu_out(mem_alu_out),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .flags(flags), .flags_fwd(flags_fwd), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_cap();
        return ex_valid && !stall && !flush && !m_halted;
    endfunction

    // Flag rule: ADD/SUB set all three, logic/shift ops set only Z, everything else leaves flags.
    function automatic logic [2:0] model_next_flags();
        logic [2:0] f;
        f = m_flags;
        if (model_cap()) begin
            if (ex_opcode inside {4'd0, 4'd1})
                f = {ex_alu_out[15], ex_alu_out == 16'd0, ex_ovfl};
            else if (ex_opcode inside {4'd2, 4'd4, 4'd5, 4'd6})
                f[1] = (ex_alu_out == 16'd0);
        end
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            {m_valid, m_rw, m_mr, m_mw, m_halted} <= 5'd0;
            m_op <= 4'd0; m_rd <= 4'd0; m_alu <= 16'd0; m_sd <= 16'd0; m_flags <= 3'b000;
        end else if (!stall && flush) begin
            {m_valid, m_rw, m_mr, m_mw} <= 4'd0;
        end else if (!stall) begin
            m_valid  <= model_cap();
            m_op     <= ex_opcode;
            m_rd     <= ex_rd;
            m_alu    <= ex_alu_out;
            m_sd     <= ex_store_data;
            m_rw     <= ex_reg_write && model_cap();
            m_mr     <= ex_mem_read && model_cap();
            m_mw     <= ex_mem_write && model_cap();
            m_flags  <= model_next_flags();
            m_halted <= m_halted || (model_cap() && ex_opcode == 4'hF);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_valid", 32'(mem_valid), 32'(m_valid));
            check("mem_opcode", 32'(mem_opcode), 32'(m_op));
            check("mem_alu_out", 32'(mem_alu_out), 32'(m_alu));
            check("mem_store_data", 32'(mem_store_data), 32'(m_sd));
            check("mem_rd", 32'(mem_rd), 32'(m_rd));
            check("mem_ctrl", 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'({m_rw, m_mr, m_mw}));
            check("flags", 32'(flags), 32'(m_flags));
            check("halted", 32'(halted), 32'(m_halted));
            if (!rst) check("flags_fwd", 32'(flags_fwd), 32'(model_next_flags()));
        end
    end

    // Apply one EX instruction for one clock edge; returns #1 after that edge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [15:0] alu, input logic ov,
                       input logic [15:0] sd, input logic [3:0] rd,
                       input logic rw, input logic mr, input logic mw);
        ex_valid = v; ex_opcode = op; ex_alu_out = alu; ex_ovfl = ov;
        ex_store_data = sd; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        cyc(1'b1, 4'(0), 16'(16'hFFFF), 1'b1, 16'(16'hAAAA), 4'd3, 1'b1, 1'b1, 1'b1);
        chk_en = 1'b1;
        cyc(1'b1, 4'($urandom_range(15)), 16'($urandom), 1'b1, 16'($urandom), 4'd5, 1'b1, 1'b0, 1'b1);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_alu", 32'(mem_alu_out), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // 1: ADD 0x7FFF+1 overflows to 0x8000
        rst = 1'b0;
        ex_valid = 1'b1; ex_opcode = 4'd0; ex_alu_out = 16'h8000; ex_ovfl = 1'b1;
        #1 check("fwd_add", 32'(flags_fwd), 32'b101);
        cyc(1'b1, 4'd0, 16'h8000, 1'b1, 16'h0001, 4'd1, 1'b1, 1'b0, 1'b0);
        check("add_alu", 32'(mem_alu_out), 32'h8000);
        check("add_flags", 32'(flags), 32'b101);

        // 2: Z-only updates leave N/V alone
        cyc(1'b1, 4'd1, 16'h0000, 1'b0, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0);
        check("sub_flags", 32'(flags), 32'b010);
        cyc(1'b1, 4'd2, 16'h1234, 1'b1, 16'h0000, 4'd2, 1'b1, 1'b0, 1'b0);
        check("xor_flags", 32'(flags), 32'b000);
        cyc(1'b1, 4'd0, 16'hFFFF, 1'b0, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b0);
        check("add_n", 32'(flags), 32'b100);
        cyc(1'b1, 4'd2, 16'h0000, 1'b0, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b0);
        check("xor_keep_n", 32'(flags), 32'b110);

        // 3: stall holds everything while EX changes
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 4'd0, 16'(16'h0100 + i), 1'b1, 16'h5555, 4'(i), 1'b1, 1'b0, 1'b1);
            check("stall_alu", 32'(mem_alu_out), 32'h0000);
            check("stall_flags", 32'(flags), 32'b110);
        end
        stall = 1'b0;
        cyc(1'b1, 4'd0, 16'h0005, 1'b0, 16'h0000, 4'd7, 1'b1, 1'b0, 1'b0);
        check("release_alu", 32'(mem_alu_out), 32'h0005);
        check("release_flags", 32'(flags), 32'b000);

        // 4: flush bubbles, stall beats flush
        flush = 1'b1;
        cyc(1'b1, 4'd0, 16'h0000, 1'b0, 16'h0000, 4'd8, 1'b1, 1'b0, 1'b0);
        check("flush_valid", 32'(mem_valid), 32'd0);
        check("flush_rw", 32'(mem_reg_write), 32'd0);
        check("flush_flags", 32'(flags), 32'b000);
        check("flush_alu_hold", 32'(mem_alu_out), 32'h0005);
        flush = 1'b0;
        cyc(1'b1, 4'd0, 16'h0003, 1'b0, 16'h0000, 4'd9, 1'b1, 1'b0, 1'b0);
        stall = 1'b1; flush = 1'b1;
        cyc(1'b1, 4'd0, 16'h0000, 1'b0, 16'h0000, 4'd9, 1'b1, 1'b0, 1'b0);
        check("stallflush_valid", 32'(mem_valid), 32'd1);
        check("stallflush_alu", 32'(mem_alu_out), 32'h0003);
        stall = 1'b0; flush = 1'b0;

        // 5: memory ops and PADDSB ignore flags and overflow
        ex_valid = 1'b1; ex_opcode = 4'd8; ex_alu_out = 16'h0000; ex_ovfl = 1'b1;
        #1 check("lw_fwd", 32'(flags_fwd), 32'(flags));
        cyc(1'b1, 4'd8, 16'h0000, 1'b1, 16'h0000, 4'd10, 1'b1, 1'b1, 1'b0);
        check("lw_ctrl", 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'b110);
        check("lw_flags", 32'(flags), 32'b000);
        cyc(1'b1, 4'd9, 16'h0000, 1'b1, 16'hBEEF, 4'd0, 1'b0, 1'b0, 1'b1);
        check("sw_ctrl", 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'b001);
        check("sw_data", 32'(mem_store_data), 32'hBEEF);
        cyc(1'b1, 4'd3, 16'h0000, 1'b1, 16'h0000, 4'd11, 1'b1, 1'b0, 1'b0);
        check("paddsb_flags", 32'(flags), 32'b000);

        // 6: flushed HLT does not halt; captured HLT does and freezes capture
        flush = 1'b1;
        cyc(1'b1, 4'hF, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        check("flush_hlt", 32'(halted), 32'd0);
        flush = 1'b0;
        cyc(1'b1, 4'hF, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_valid", 32'(mem_valid), 32'd1);
        cyc(1'b1, 4'd0, 16'h0000, 1'b0, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0);
        check("halted_valid", 32'(mem_valid), 32'd0);
        check("halted_flags", 32'(flags), 32'b000);
        rst = 1'b1;
        cyc(1'b1, 4'd0, 16'h0000, 1'b0, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0);
        check("rst_clears_halt", 32'(halted), 32'd0);
        rst = 1'b0;
        cyc(1'b1, 4'd0, 16'h0000, 1'b0, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b0);
        check("resume_valid", 32'(mem_valid), 32'd1);
        check("resume_flags", 32'(flags), 32'b010);
        cyc(1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
        check("bubble_valid", 32'(mem_valid), 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
